uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler sharing one UART transmitter datapath between NUM_REQ byte requesters. Each requester presents a byte with valid. The arbiter grants one requester, latches its byte, pulses the transmitter start, and waits for the frame to finish before granting again. It sits between the host-side byte sources and the single uart_tx instance, alongside uart_rx on the same sysclk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
data_bits, 8, UART data word width
REQ_ID_BITS, 2, width of grant index (ceil log2 NUM_REQ)

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte pending
req_data  in  NUM_REQ*data_bits  byte of requester i at bits [i*data_bits +: data_bits]
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
tx_start  out  1  one-cycle pulse to transmitter: begin frame
tx_data  out  data_bits  byte to transmit, held stable from tx_start until frame done
tx_busy  in  1  transmitter frame in progress
grant_id  out  REQ_ID_BITS  index of current/last granted requester
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at edge) values: req_ack=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, state=IDLE, rr pointer last=NUM_REQ-1, so requester 0 has first priority. Reset mid-frame aborts to IDLE immediately. The transmitter is not notified.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, select the first set bit searching last+1, last+2, … with wrap modulo NUM_REQ.
  - Register grant_id=sel, tx_data=req_data[sel], req_ack[sel]=1 for one cycle, last=sel, then go to ISSUE.
  - If no req_valid is set, remain in IDLE.
- ISSUE: tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. The transmitter raises busy within 2 cycles of tx_start.
  - If tx_busy is still 0 after 4 cycles in WAIT_BUSY, return to IDLE. The frame counts as sent.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0, go to IDLE.
  - The next grant occurs the cycle after IDLE is re-entered.
  - Minimum spacing between tx_start pulses is 4 cycles plus frame time.
- Requester contract: a requester deasserts valid or presents its next byte the cycle after its req_ack.
  - Valid dropping before grant is legal; the byte is simply not sent.
- Simultaneous requests: strict round-robin. A requester holding valid continuously is served at most once per NUM_REQ grants while others are pending.
- A single active requester is re-granted back-to-back.
- req_valid changes outside IDLE are ignored until the next IDLE evaluation.
- tx_data holds its value between frames (not cleared).

Optional Feature:
UART_ARB_LOCK_EN:
- Defined: adds input port req_lock [NUM_REQ]. If the currently granted requester has req_lock=1 and req_valid=1 in IDLE, it is granted again regardless of the rr pointer (burst/packet mode). When its lock drops, round-robin resumes from last+1.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package uart_pkg: FSM state enum (arb_state_t, 2 bits), WAIT_BUSY_TIMEOUT=4, common data_bits default shared with uart_rx/uart_tx.
- Sub-module rr_priority_select: combinational-plus-pointer round-robin picker. Inputs req vector and last index; outputs sel index and any_req. Reused by future arbiters.

Test Plan:
- Single requester: rst pulse, then req_valid=4'b0001, req_data[7:0]=8'hA5 → req_ack[0] one cycle, tx_start one cycle later, tx_data=8'hA5, grant_id=0; a tx_busy model of 10 cycles gives arb_busy low again after tx_busy falls.
- All four valid continuously with bytes 8'h10,8'h21,8'h32,8'h43 → tx_data sequence 10,21,32,43,10… with grant_id 0,1,2,3,0.
- Requester 2 only, re-presenting new bytes after each ack → back-to-back grants to 2 with no starvation gap beyond FSM overhead.
- tx_busy never asserted after tx_start → return to IDLE after 4 WAIT_BUSY cycles, next requester granted.
- rst=1 asserted during WAIT_DONE → next cycle all outputs at reset values, state IDLE; after release, requester 0 wins over 3 when both are valid.
- With UART_ARB_LOCK_EN: req 1 locked with 3 bytes while req 0 is also valid → three consecutive grants to 1, then 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, arbiter FSM encoding and the
// WAIT_BUSY timeout used by uart_tx_arbiter. Imported by uart_rx/uart_tx too.
package uart_pkg;

    // Default UART data word width, common to rx, tx and the arbiter.
    localparam int unsigned UART_DATA_BITS = 8;

    // Cycles spent in WAIT_BUSY without tx_busy before the frame is written off.
    localparam int unsigned WAIT_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority picker: returns the first set request searching from
// i_last+1 upward with wraparound. Purely combinational; the caller owns the
// pointer register.
//   i_req       : request vector
//   i_last      : index granted last time (lowest priority this round)
//   o_sel_c     : selected index (holds i_last when nothing is requested)
//   o_any_req_c : at least one request is set
module rr_priority_select #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned REQ_ID_BITS = 2
) (
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [REQ_ID_BITS-1:0] i_last,
    output logic [REQ_ID_BITS-1:0] o_sel_c,
    output logic                   o_any_req_c
);

    logic                   w_found_hi;
    logic                   w_found_lo;
    logic [REQ_ID_BITS-1:0] w_sel_hi;
    logic [REQ_ID_BITS-1:0] w_sel_lo;

    // Two scans: first set bit above i_last, else first set bit overall (wrap).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i_req[i]) begin
                if (!w_found_hi && (REQ_ID_BITS'(i) > i_last)) begin
                    w_sel_hi   = REQ_ID_BITS'(i);
                    w_found_hi = 1'b1;
                end
                if (!w_found_lo) begin
                    w_sel_lo   = REQ_ID_BITS'(i);
                    w_found_lo = 1'b1;
                end
            end
        end
        o_any_req_c = w_found_lo;
        if (w_found_hi) begin
            o_sel_c = w_sel_hi;
        end else if (w_found_lo) begin
            o_sel_c = w_sel_lo;
        end else begin
            o_sel_c = i_last;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Grants in IDLE, acks the requester, pulses tx_start, then waits for the
// transmitter frame (tx_busy) to finish before the next grant.
// Optional macro UART_ARB_LOCK_EN adds req_lock: a locked, valid requester
// that holds the current grant is re-granted ahead of the round-robin order.
//   sysclk    : clock, all logic on rising edge
//   rst       : synchronous active-high reset
//   req_valid : per-requester byte pending
//   req_data  : requester i byte at [i*data_bits +: data_bits]
//   req_lock  : (UART_ARB_LOCK_EN only) burst lock per requester
//   req_ack   : one-cycle accept pulse per requester
//   tx_start  : one-cycle frame start to the transmitter
//   tx_data   : byte to transmit, held until the next grant
//   tx_busy   : transmitter frame in progress
//   grant_id  : current/last granted requester
//   arb_busy  : arbiter not in IDLE
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned data_bits   = UART_DATA_BITS,
    parameter int unsigned REQ_ID_BITS = 2
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*data_bits-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_lock,
`endif
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         tx_start,
    output logic [data_bits-1:0]         tx_data,
    input  logic                         tx_busy,
    output logic [REQ_ID_BITS-1:0]       grant_id,
    output logic                         arb_busy
);

    localparam int unsigned TO_W = $clog2(WAIT_BUSY_TIMEOUT);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [REQ_ID_BITS-1:0] r_last;
    logic [REQ_ID_BITS-1:0] w_last_nxt;
    logic [TO_W-1:0]        r_wait_cnt;
    logic [TO_W-1:0]        w_wait_cnt_nxt;
    logic [NUM_REQ-1:0]     r_req_ack;
    logic [NUM_REQ-1:0]     w_req_ack_nxt;
    logic                   r_tx_start;
    logic                   w_tx_start_nxt;
    logic [data_bits-1:0]   r_tx_data;
    logic [data_bits-1:0]   w_tx_data_nxt;
    logic [REQ_ID_BITS-1:0] r_grant_id;
    logic [REQ_ID_BITS-1:0] w_grant_id_nxt;
    logic                   r_arb_busy;

    logic [REQ_ID_BITS-1:0] w_rr_sel;
    logic                   w_any_req;
    logic [REQ_ID_BITS-1:0] w_pick;
    logic [data_bits-1:0]   w_pick_data;

    rr_priority_select #(
        .NUM_REQ     (NUM_REQ),
        .REQ_ID_BITS (REQ_ID_BITS)
    ) u_rr_sel (
        .i_req       (req_valid),
        .i_last      (r_last),
        .o_sel_c     (w_rr_sel),
        .o_any_req_c (w_any_req)
    );

`ifdef UART_ARB_LOCK_EN
    logic w_lock_hit;

    // Current holder keeps the grant while it is both locked and valid.
    always_comb begin
        w_lock_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (REQ_ID_BITS'(i) == r_grant_id) begin
                w_lock_hit = req_lock[i] & req_valid[i];
            end
        end
        w_pick = w_lock_hit ? r_grant_id : w_rr_sel;
    end
`else
    assign w_pick = w_rr_sel;
`endif

    // Byte of the picked requester.
    always_comb begin
        w_pick_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (REQ_ID_BITS'(i) == w_pick) begin
                w_pick_data = req_data[i*data_bits +: data_bits];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_wait_cnt_nxt = r_wait_cnt;
        w_req_ack_nxt  = '0;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_grant_id_nxt = r_grant_id;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_id_nxt = w_pick;
                    w_tx_data_nxt  = w_pick_data;
                    w_last_nxt     = w_pick;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        w_req_ack_nxt[i] = (REQ_ID_BITS'(i) == w_pick);
                    end
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_tx_start_nxt = 1'b1;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never answers must not hang the arbiter.
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_wait_cnt == TO_W'(WAIT_BUSY_TIMEOUT - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= REQ_ID_BITS'(NUM_REQ - 1);
            r_wait_cnt <= '0;
            r_req_ack  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_arb_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_req_ack  <= w_req_ack_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_arb_busy <= (w_state_nxt != IDLE);
        end
    end

    assign req_ack  = r_req_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign arb_busy = r_arb_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural round-robin
// model and a simple transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;

    logic             sysclk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DB-1:0] req_data;
    logic [NR-1:0]    req_lock;
    logic [NR-1:0]    req_ack;
    logic             tx_start;
    logic [DB-1:0]    tx_data;
    logic             tx_busy;
    logic [1:0]       grant_id;
    logic             arb_busy;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .data_bits   (DB),
        .REQ_ID_BITS (2)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ack   (req_ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #5 sysclk = ~sysclk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state
    int  m_last;
    int  m_grant;
    bit  m_idle;
    int  rem[NR];
    bit  keep_data;
    bit  rand_valid;
    bit  cfg_never;
    int  cfg_d;
    int  cfg_l;
    int  got_seq[$];
    int  bm_wait;
    int  bm_left;

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    // Who should win given the valid/lock vectors seen at the grant edge.
    function automatic int rr_pick(input logic [NR-1:0] v, input logic [NR-1:0] lk);
        int idx;
        if (lk[m_grant] && v[m_grant]) return m_grant;
        for (int off = 1; off <= NR; off++) begin
            idx = (m_last + off) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        tx_busy   = 1'b0;
        bm_wait   = 0;
        bm_left   = 0;
        tick();
        tick();
        rst        = 1'b0;
        m_last     = NR - 1;
        m_grant    = 0;
        m_idle     = 1'b1;
        keep_data  = 1'b0;
        rand_valid = 1'b0;
        cfg_never  = 1'b0;
        cfg_d      = 0;
        cfg_l      = 0;
        got_seq.delete();
        for (int i = 0; i < NR; i++) rem[i] = 0;
    endtask

    // Runs until n grants have been made and the last frame is complete.
    task automatic run_grants(input int n);
        logic [NR-1:0]    pv;
        logic [NR-1:0]    plk;
        logic [NR*DB-1:0] pd;
        logic [DB-1:0]    exp_byte;
        bit idle_before, pend, open, started;
        int ack_cyc, idle_cyc, idx, e, grants, budget, d, l;
        grants = 0; pend = 0; open = 0; ack_cyc = 0; idle_cyc = -1;
        exp_byte = '0; budget = 0; d = 1; l = 1;
        while (!(grants >= n && !pend && !open)) begin
            if (budget == 3000) begin
                vectors++; miscompares++;
                $display("FAIL run_budget grants=%0d required=%0d", grants, n);
                break;
            end
            budget++;
            if (rand_valid && grants < n) begin
                req_valid = NR'($urandom_range(0, (1 << NR) - 1));
                req_data  = $urandom;
            end
            pv = req_valid; pd = req_data; plk = req_lock; idle_before = m_idle;
            tick();
            started = tx_start;

            vectors++;
            if ((req_ack != '0) !== (idle_before && (pv != '0))) begin
                miscompares++;
                $display("FAIL ack_timing cyc=%0d ack=%b valid=%b expected_grant=%0d",
                         cyc, req_ack, pv, idle_before && (pv != '0));
            end
            if (req_ack != '0) begin
                idx = -1;
                for (int i = 0; i < NR; i++) if (req_ack[i]) idx = i;
                e = rr_pick(pv, plk);
                vectors++;
                if ($countones(req_ack) != 1 || idx != e) begin
                    miscompares++;
                    $display("FAIL rr_grant ack=%b required_index=%0d", req_ack, e);
                end
                vectors++;
                if (grant_id !== 2'(e)) begin
                    miscompares++;
                    $display("FAIL grant_id got=%0d required=%0d", grant_id, e);
                end
                vectors++;
                if (arb_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL arb_busy_on got=%b required=1", arb_busy);
                end
                if (e >= 0) begin
                    m_last = e; m_grant = e;
                    exp_byte = pd[e*DB +: DB];
                end
                m_idle = 1'b0; pend = 1'b1; ack_cyc = cyc;
                got_seq.push_back(idx);
                grants++;
                if (idx >= 0) begin
                    rem[idx]--;
                    if (rem[idx] <= 0) begin
                        req_valid[idx] = 1'b0;
                        req_lock[idx]  = 1'b0;
                    end else if (!keep_data) begin
                        req_data[idx*DB +: DB] = DB'($urandom);
                    end
                end
                if (grants >= n) begin
                    req_valid = '0;
                    req_lock  = '0;
                end
            end

            if (started) begin
                vectors++;
                if (!pend || cyc != ack_cyc + 1) begin
                    miscompares++;
                    $display("FAIL tx_start_timing cyc=%0d ack_cyc=%0d required=%0d", cyc, ack_cyc, ack_cyc + 1);
                end
                vectors++;
                if (tx_data !== exp_byte) begin
                    miscompares++;
                    $display("FAIL tx_data got=%h required=%h", tx_data, exp_byte);
                end
                pend = 1'b0; open = 1'b1;
                d = (cfg_d != 0) ? cfg_d : $urandom_range(1, 2);
                l = (cfg_l != 0) ? cfg_l : $urandom_range(1, 8);
                idle_cyc = cyc + (cfg_never ? 4 : d + l);
            end else if (pend && cyc > ack_cyc + 1) begin
                vectors++; miscompares++;
                $display("FAIL tx_start_missing cyc=%0d ack_cyc=%0d", cyc, ack_cyc);
                pend = 1'b0;
            end else if (open) begin
                vectors++;
                if (tx_data !== exp_byte) begin
                    miscompares++;
                    $display("FAIL tx_data_hold got=%h required=%h", tx_data, exp_byte);
                end
            end

            if (open && cyc == idle_cyc) begin
                vectors++;
                if (arb_busy !== 1'b0 || tx_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arb_idle cyc=%0d arb_busy=%b tx_start=%b required=0,0", cyc, arb_busy, tx_start);
                end
                open = 1'b0; m_idle = 1'b1;
            end

            // Transmitter model: busy rises d cycles after start, lasts l cycles.
            if (bm_wait > 0) begin
                bm_wait--;
                if (bm_wait == 0) tx_busy = 1'b1;
            end else if (tx_busy) begin
                bm_left--;
                if (bm_left == 0) tx_busy = 1'b0;
            end
            if (started && !cfg_never) begin
                bm_left = l;
                if (d == 1) tx_busy = 1'b1;
                else        bm_wait = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = $urandom; req_lock = '0; tx_busy = 1'b0;
        tick();
        tick();
        vectors++;
        if (req_ack !== '0) begin miscompares++; $display("FAIL reset_ack got=%b required=0", req_ack); end
        vectors++;
        if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start got=%b required=0", tx_start); end
        vectors++;
        if (tx_data !== '0) begin miscompares++; $display("FAIL reset_tx_data got=%h required=0", tx_data); end
        vectors++;
        if (grant_id !== '0) begin miscompares++; $display("FAIL reset_grant_id got=%0d required=0", grant_id); end
        vectors++;
        if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL reset_arb_busy got=%b required=0", arb_busy); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; rem[0] = 1;
        cfg_d = 1; cfg_l = 10;
        run_grants(1);
        vectors++;
        if (got_seq.size() != 1 || got_seq[0] != 0) begin
            miscompares++; $display("FAIL single_grant count=%0d required one grant to 0", got_seq.size());
        end
        vectors++;
        if (tx_data !== 8'hA5 || arb_busy !== 1'b0) begin
            miscompares++; $display("FAIL single_end tx_data=%h arb_busy=%b required=a5,0", tx_data, arb_busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111; req_data = 32'h43322110; keep_data = 1'b1;
        for (int i = 0; i < NR; i++) rem[i] = 100;
        run_grants(8);
        vectors++;
        if (got_seq.size() != 8) begin
            miscompares++; $display("FAIL rr_count got=%0d required=8", got_seq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_seq[i] != i % NR) begin
                    miscompares++; $display("FAIL rr_order idx=%0d got=%0d required=%0d", i, got_seq[i], i % NR);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0100; req_data = $urandom; rem[2] = 6;
        cfg_d = 1; cfg_l = 1;
        run_grants(6);
        vectors++;
        if (got_seq.size() != 6) begin
            miscompares++; $display("FAIL b2b_count got=%0d required=6", got_seq.size());
        end
        foreach (got_seq[i]) begin
            vectors++;
            if (got_seq[i] != 2) begin miscompares++; $display("FAIL b2b_id got=%0d required=2", got_seq[i]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cfg_never = 1'b1;
        req_valid = 4'b0011; req_data = $urandom; rem[0] = 2; rem[1] = 2;
        run_grants(4);
        vectors++;
        if (got_seq.size() != 4) begin
            miscompares++; $display("FAIL timeout_count got=%0d required=4", got_seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got_seq[i] != i % 2) begin
                    miscompares++; $display("FAIL timeout_order idx=%0d got=%0d required=%0d", i, got_seq[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DB-1:0] b;
        int n;
        do_reset();
        b = DB'($urandom_range(1, 255));
        req_valid = 4'b0010; req_data = $urandom; req_data[15:8] = b;
        tick();
        vectors++;
        if (req_ack !== 4'b0010 || grant_id !== 2'd1) begin
            miscompares++; $display("FAIL mid_first_grant ack=%b id=%0d required=0010,1", req_ack, grant_id);
        end
        req_valid = '0;
        tick();
        vectors++;
        if (tx_start !== 1'b1) begin miscompares++; $display("FAIL mid_tx_start got=%b required=1", tx_start); end
        tx_busy = 1'b1;
        tick();
        tick();
        vectors++;
        if (arb_busy !== 1'b1 || tx_data !== b) begin
            miscompares++; $display("FAIL mid_wait_done arb_busy=%b tx_data=%h required=1,%h", arb_busy, tx_data, b);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (req_ack !== '0 || tx_start !== 1'b0 || tx_data !== '0 || grant_id !== '0 || arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset ack=%b start=%b data=%h id=%0d busy=%b required all 0",
                     req_ack, tx_start, tx_data, grant_id, arb_busy);
        end
        rst = 1'b0; tx_busy = 1'b0; req_valid = 4'b1001;
        tick();
        vectors++;
        if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin
            miscompares++; $display("FAIL mid_after_reset ack=%b id=%0d required=0001,0", req_ack, grant_id);
        end
        req_valid = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (arb_busy && n < 30);
        vectors++;
        if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL mid_drain arb_busy=%b required=0", arb_busy); end
    endtask

    task automatic test_random();
        do_reset();
        rand_valid = 1'b1;
        for (int i = 0; i < NR; i++) rem[i] = 1000;
        run_grants(40);
        vectors++;
        if (got_seq.size() != 40) begin
            miscompares++; $display("FAIL random_count got=%0d required=40", got_seq.size());
        end
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        int exp_l[5] = '{0, 1, 1, 1, 0};
        do_reset();
        req_valid = 4'b0011; req_lock = 4'b0010; req_data = $urandom;
        rem[0] = 2; rem[1] = 3;
        run_grants(5);
        vectors++;
        if (got_seq.size() != 5) begin
            miscompares++; $display("FAIL lock_count got=%0d required=5", got_seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got_seq[i] != exp_l[i]) begin
                    miscompares++; $display("FAIL lock_order idx=%0d got=%0d required=%0d", i, got_seq[i], exp_l[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; tx_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_random();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
